// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
// Shared types and constants for the pushbutton conditioner:
//   - chan_state_e   : per-channel debounce FSM states
//   - DEFAULT_*      : default timing constants (in clk cycles)
//   - CH_*           : channel indices used for the candidate vector
//   - cntWidth()     : counter width helper (clog2 of the largest count)
// Optional feature macro: BUTTON_AUTOREPEAT_EN (auto-repeat on left/right).
// ---------------------------------------------------------------------------
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } chan_state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEFAULT_REPEAT_DELAY    = 40_000_000;
  localparam int DEFAULT_REPEAT_RATE     = 10_000_000;

  localparam int CH_DROP = 0;
  localparam int CH_L    = 1;
  localparam int CH_R    = 2;
  localparam int NUM_CH  = 3;

  // Counters only ever hold values up to (parameter - 1), so clog2 of the
  // largest parameter is always wide enough. Never returns less than 1.
  function automatic int cntWidth(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One pushbutton channel: 2-flop synchroniser, 4-state debounce FSM with a
// saturating counter, and (when BUTTON_AUTOREPEAT_EN is defined) an
// auto-repeat timer. Produces an unregistered single-cycle candidate pulse;
// arbitration, lock gating and output registering live in the parent.
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   raw_i        in   asynchronous bouncy button (active high)
//   repeat_en_i  in   enables auto-repeat for this channel
//   cand_o       out  candidate press/repeat pulse (combinational)
// Optional feature macro: BUTTON_AUTOREPEAT_EN.
// ---------------------------------------------------------------------------
module debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEFAULT_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  input  logic repeat_en_i,
  output logic cand_o
);

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int CNT_W = cntWidth(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
`else
  localparam int CNT_W = cntWidth(DEBOUNCE_CYCLES, DEBOUNCE_CYCLES, DEBOUNCE_CYCLES);
`endif

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             sample;
  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_cand;
  logic             rep_cand;

  // Two-flop synchroniser; nothing else looks at raw_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], raw_i};
  end

  assign sample = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The press candidate is raised on the cycle the FSM commits to HELD, so
  // the parent's output register fires on the same edge as the transition.
  // Counting stops at DEB_LAST, so the counter can never wrap.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    press_cand = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sample) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sample) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_LAST) begin
          state_d    = HELD;
          cnt_d      = '0;
          press_cand = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!sample) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sample) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             rphase_q, rphase_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q   <= '0;
      rphase_q <= 1'b0;
    end else begin
      rcnt_q   <= rcnt_d;
      rphase_q <= rphase_d;
    end
  end

  // Repeat timer restarts on the press pulse; rphase_q selects between the
  // initial delay and the steady repeat rate. Held bounces in RELEASE_WAIT
  // keep the timer running since the key is logically still down.
  always_comb begin
    rcnt_d   = rcnt_q;
    rphase_d = rphase_q;
    rep_cand = 1'b0;
    if (press_cand) begin
      rcnt_d   = '0;
      rphase_d = 1'b0;
    end else if (state_q == HELD || state_q == RELEASE_WAIT) begin
      if (rcnt_q >= (rphase_q ? RATE_LAST : DELAY_LAST)) begin
        rep_cand = repeat_en_i;
        rcnt_d   = '0;
        rphase_d = 1'b1;
      end else begin
        rcnt_d = rcnt_q + 1'b1;
      end
    end else begin
      rcnt_d   = '0;
      rphase_d = 1'b0;
    end
  end
`else
  logic unused_repeat_en;
  assign unused_repeat_en = repeat_en_i;
  assign rep_cand         = 1'b0;
`endif

  assign cand_o = press_cand | rep_cand;

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// Conditions three bouncy pushbuttons into single-cycle press pulses for the
// game core. Each button runs through its own debounce_channel; this level
// arbitrates simultaneous candidates (drop > left > right, losers dropped),
// suppresses everything while lock is high, and registers the outputs so at
// most one is high per cycle.
// Ports:
//   clk                 in   system clock, rising edge
//   rst_n               in   asynchronous active-low reset
//   raw_l/raw_r/raw_drop in  asynchronous bouncy buttons (active high)
//   lock                in   synchronous; suppresses all pulses when high
//   btn_l/btn_r/btn_drop out registered single-cycle press pulses
// Optional feature macro: BUTTON_AUTOREPEAT_EN (left/right auto-repeat).
// ---------------------------------------------------------------------------
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEFAULT_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_l,
  input  logic raw_r,
  input  logic raw_drop,
  input  logic lock,
  output logic btn_l,
  output logic btn_r,
  output logic btn_drop
);

  logic [NUM_CH-1:0] cand;
  logic [NUM_CH-1:0] raw_vec;
  logic [NUM_CH-1:0] rep_en;
  logic              btn_l_q, btn_l_d;
  logic              btn_r_q, btn_r_d;
  logic              btn_drop_q, btn_drop_d;

  assign raw_vec[CH_DROP] = raw_drop;
  assign raw_vec[CH_L]    = raw_l;
  assign raw_vec[CH_R]    = raw_r;

  // Drop never auto-repeats; left and right may.
  assign rep_en[CH_DROP] = 1'b0;
  assign rep_en[CH_L]    = 1'b1;
  assign rep_en[CH_R]    = 1'b1;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw_i      (raw_vec[ch]),
      .repeat_en_i(rep_en[ch]),
      .cand_o     (cand[ch])
    );
  end

  // Fixed-priority pick; lower-priority candidates in the same cycle are
  // simply lost, and lock discards everything without stalling the FSMs.
  always_comb begin
    btn_drop_d = 1'b0;
    btn_l_d    = 1'b0;
    btn_r_d    = 1'b0;
    if (!lock) begin
      if (cand[CH_DROP])   btn_drop_d = 1'b1;
      else if (cand[CH_L]) btn_l_d    = 1'b1;
      else if (cand[CH_R]) btn_r_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_drop_q <= 1'b0;
      btn_l_q    <= 1'b0;
      btn_r_q    <= 1'b0;
    end else begin
      btn_drop_q <= btn_drop_d;
      btn_l_q    <= btn_l_d;
      btn_r_q    <= btn_r_d;
    end
  end

  assign btn_drop = btn_drop_q;
  assign btn_l    = btn_l_q;
  assign btn_r    = btn_r_q;

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
// Directed self-checking bench for button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_RATE=5. Offsets are counted from the first clock
// edge that samples the new raw level (offset 0). Expected auto-repeat
// behaviour follows BUTTON_AUTOREPEAT_EN.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RR  = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic raw_l, raw_r, raw_drop, lock;
  logic btn_l, btn_r, btn_drop;

  int checks   = 0;
  int failures = 0;
  int multiHot = 0;
  int qDrop[$];
  int qL[$];
  int qR[$];
  int expL[$];

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_l   (raw_l),
    .raw_r   (raw_r),
    .raw_drop(raw_drop),
    .lock    (lock),
    .btn_l   (btn_l),
    .btn_r   (btn_r),
    .btn_drop(btn_drop)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Inputs change only at the falling edge, away from the sampling edge.
  task automatic applyStimulus(input logic dropV, input logic lV, input logic rV, input logic lockV);
    raw_drop = dropV;
    raw_l    = lV;
    raw_r    = rV;
    lock     = lockV;
  endtask

  // Advance one rising edge, sample outputs just after it, log pulses with
  // their offset, and return to the following falling edge.
  task automatic stepCycle(input int k);
    @(posedge clk);
    #1;
    if (btn_drop) qDrop.push_back(k);
    if (btn_l)    qL.push_back(k);
    if (btn_r)    qR.push_back(k);
    if ((int'(btn_drop) + int'(btn_l) + int'(btn_r)) > 1) multiHot++;
    @(negedge clk);
  endtask

  task automatic clearLog();
    qDrop.delete();
    qL.delete();
    qR.delete();
  endtask

  task automatic drain(input int n);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < n; k++) stepCycle(100 + k);
    clearLog();
  endtask

  function automatic int firstOr(input int sz, input int v);
    return (sz > 0) ? v : -1;
  endfunction

  initial begin
    int pat[5];
    pat = '{1, 0, 1, 0, 1};
`ifdef BUTTON_AUTOREPEAT_EN
    expL = '{6, 16, 21, 26};
`else
    expL = '{6};
`endif

    // Reset state
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("reset_drop", int'(btn_drop), 0);
    checkOutput("reset_l", int'(btn_l), 0);
    checkOutput("reset_r", int'(btn_r), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) stepCycle(k);
    checkOutput("idle_no_pulse", qDrop.size() + qL.size() + qR.size(), 0);
    clearLog();

    // Clean press on drop: one pulse at offset 6, never repeats
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      stepCycle(k);
    end
    checkOutput("clean_drop_count", qDrop.size(), 1);
    checkOutput("clean_drop_at", firstOr(qDrop.size(), (qDrop.size() > 0) ? qDrop[0] : 0), 6);
    checkOutput("clean_others", qL.size() + qR.size(), 0);
    drain(15);

    // Bounce on left: final rise at offset 4, pulse at 10
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, (k < 5) ? pat[k][0] : 1'b1, 1'b0, 1'b0);
      stepCycle(k);
    end
    checkOutput("bounce_l_count", qL.size(), 1);
    checkOutput("bounce_l_at", firstOr(qL.size(), (qL.size() > 0) ? qL[0] : 0), 10);
    checkOutput("bounce_others", qDrop.size() + qR.size(), 0);
    drain(15);

    // Simultaneous drop and right: drop wins, right is discarded
    for (int k = 0; k < 15; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      stepCycle(k);
    end
    checkOutput("simul_drop_count", qDrop.size(), 1);
    checkOutput("simul_drop_at", firstOr(qDrop.size(), (qDrop.size() > 0) ? qDrop[0] : 0), 6);
    checkOutput("simul_r_count", qR.size(), 0);
    drain(20);

    // Lock during a right press, cleared while still held: no pulse
    for (int k = 0; k < 14; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, (k < 10) ? 1'b1 : 1'b0);
      stepCycle(k);
    end
    checkOutput("lock_r_count", qR.size(), 0);
    drain(20);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      stepCycle(k);
    end
    checkOutput("relock_r_count", qR.size(), 1);
    checkOutput("relock_r_at", firstOr(qR.size(), (qR.size() > 0) ? qR[0] : 0), 6);
    drain(20);

    // Held left for 30 cycles: auto-repeat schedule depends on the macro
    for (int k = 0; k < 30; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      stepCycle(k);
    end
    checkOutput("repeat_l_count", qL.size(), expL.size());
    for (int i = 0; i < expL.size(); i++) begin
      checkOutput($sformatf("repeat_l_at%0d", i), (i < qL.size()) ? qL[i] : -1, expL[i]);
    end
    checkOutput("repeat_others", qDrop.size() + qR.size(), 0);
    drain(25);

    // Reset during the right-press debounce: press discarded, then re-debounced
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      stepCycle(k);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_outputs", int'(btn_drop) + int'(btn_l) + int'(btn_r), 0);
    for (int k = 3; k < 8; k++) stepCycle(k);
    checkOutput("midrst_no_pulse_in_reset", qDrop.size() + qL.size() + qR.size(), 0);
    rst_n = 1'b1;
    clearLog();
    for (int k = 0; k < 12; k++) stepCycle(k);
    checkOutput("postrst_r_count", qR.size(), 1);
    checkOutput("postrst_r_at", firstOr(qR.size(), (qR.size() > 0) ? qR[0] : 0), 6);
    drain(20);

    checkOutput("onehot_violations", multiHot, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
